fpu_bus_master: RTL and testbench

Host-side initiator for the FPU's byte-wide register bus. It accepts a 32-bit operand pair and an opcode from a parallel host port and serialises them into byte writes. It then issues the command write, waits for the FPU's `cmd_end`, reads back the 32-bit result bytewise and acknowledges completion. It lets on-chip logic use the FPU without CPU bus cycles and drives exactly the pin protocol the FPU expects.

---
 rtl/fpu_bus_master.sv | 191 +++++++++++++++++++
 tb/tb_fpu_bus_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_bus_master.sv
// fpu_bus_master: host-side initiator for the FPU byte bus. It serialises an operand pair and an
// opcode into byte writes, waits for cmd_end, reads the 32-bit result back and acknowledges.
module fpu_bus_master #(
    parameter int unsigned STROBE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [5:0]  CMD_ADDR       = 6'h08,
    parameter logic [5:0]  RES_ADDR       = 6'h09
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [7:0]  opcode,
    output logic [31:0] result,
    output logic        done,
    output logic        error,
    output logic        host_busy,
    output logic [5:0]  addr,
    output logic [7:0]  databus_out,
    input  logic [7:0]  databus_in,
    output logic        cs,
    output logic        wr,
    output logic        rd,
    output logic        end_ack,
    input  logic        cmd_end,
    input  logic        fpu_busy
);

    typedef enum logic [2:0] {
        StIdle, StWaitFree, StWrOps, StWrCmd, StWaitEnd, StRdRes, StAck, StDone
    } state_e;

    localparam logic [15:0] StbLast = 16'(STROBE_CYCLES - 1);

    state_e      state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [7:0]  op_q;
    logic [31:0] res_q;   // result assembled during reads, published with done
    logic [31:0] tmo_q;
    logic [2:0]  idx_q;
    logic [15:0] stb_q;

    logic [63:0] ops;
    logic [2:0]  idx_nxt;
    logic        stb_last;

    assign ops      = {b_q, a_q};
    assign idx_nxt  = idx_q + 3'd1;
    assign stb_last = (stb_q == StbLast);

    // Transaction sequencer; every bus pin is driven from a register so strobes are glitch-free.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            tmo_q       <= '0;
            idx_q       <= '0;
            stb_q       <= '0;
            result      <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            host_busy   <= 1'b0;
            addr        <= '0;
            databus_out <= '0;
            cs          <= 1'b1;
            wr          <= 1'b1;
            rd          <= 1'b1;
            end_ack     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q       <= op_a;
                        b_q       <= op_b;
                        op_q      <= opcode;
                        error     <= 1'b0;
                        host_busy <= 1'b1;
                        state_q   <= StWaitFree;
                    end
                end
                StWaitFree: begin
                    if (!fpu_busy) begin
                        idx_q       <= '0;
                        stb_q       <= '0;
                        addr        <= 6'd0;
                        databus_out <= a_q[7:0];
                        cs          <= 1'b0;
                        wr          <= 1'b0;
                        state_q     <= StWrOps;
                    end
                end
                StWrOps: begin
                    if (!cs) begin
                        if (stb_last) begin
                            cs <= 1'b1;
                            wr <= 1'b1;
                        end else begin
                            stb_q <= stb_q + 16'd1;
                        end
                    end else if (idx_q != 3'd7) begin
                        // Gap cycle done: bytes 0..3 come from op_a, 4..7 from op_b.
                        idx_q       <= idx_nxt;
                        stb_q       <= '0;
                        addr        <= {3'b000, idx_nxt};
                        databus_out <= ops[{idx_nxt, 3'b000} +: 8];
                        cs          <= 1'b0;
                        wr          <= 1'b0;
                    end else begin
                        stb_q       <= '0;
                        addr        <= CMD_ADDR;
                        databus_out <= op_q;
                        cs          <= 1'b0;
                        wr          <= 1'b0;
                        state_q     <= StWrCmd;
                    end
                end
                StWrCmd: begin
                    if (!cs) begin
                        if (stb_last) begin
                            cs <= 1'b1;
                            wr <= 1'b1;
                        end else begin
                            stb_q <= stb_q + 16'd1;
                        end
                    end else begin
                        tmo_q   <= '0;
                        state_q <= StWaitEnd;
                    end
                end
                StWaitEnd: begin
                    if (cmd_end) begin
                        idx_q   <= '0;
                        stb_q   <= '0;
                        addr    <= RES_ADDR;
                        cs      <= 1'b0;
                        rd      <= 1'b0;
                        state_q <= StRdRes;
                    end else if ((TIMEOUT_CYCLES != 0) && (tmo_q + 32'd1 == TIMEOUT_CYCLES)) begin
                        error   <= 1'b1;
                        res_q   <= '0;
                        end_ack <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                StRdRes: begin
                    if (!cs) begin
                        if (stb_last) begin
                            res_q[{idx_q[1:0], 3'b000} +: 8] <= databus_in;
                            cs <= 1'b1;
                            rd <= 1'b1;
                        end else begin
                            stb_q <= stb_q + 16'd1;
                        end
                    end else if (idx_q != 3'd3) begin
                        idx_q <= idx_nxt;
                        stb_q <= '0;
                        addr  <= RES_ADDR + {3'b000, idx_nxt};
                        cs    <= 1'b0;
                        rd    <= 1'b0;
                    end else begin
                        end_ack <= 1'b1;
                        state_q <= StAck;
                    end
                end
                StAck: begin
                    // After a timeout the FPU never raised cmd_end, so do not wait on it.
                    if (error || !cmd_end) begin
                        end_ack <= 1'b0;
                        result  <= res_q;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    host_busy <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_bus_master.sv
// Self-checking bench for fpu_bus_master with a behavioural FPU register-bus model.
module tb_fpu_bus_master;

    localparam int unsigned TMO    = 16;
    localparam logic [5:0]  CMD_A  = 6'h08;
    localparam logic [5:0]  RES_A  = 6'h09;
    localparam logic [7:0]  OP_DIV = 8'h03;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [7:0]  opcode = '0;
    logic [31:0] result;
    logic        done, error, host_busy;
    logic [5:0]  addr;
    logic [7:0]  databus_out;
    logic [7:0]  databus_in;
    logic        cs, wr, rd, end_ack;
    logic        cmd_end;
    logic        fpu_busy = 1'b0;

    fpu_bus_master #(
        .STROBE_CYCLES (1),
        .TIMEOUT_CYCLES(TMO),
        .CMD_ADDR      (CMD_A),
        .RES_ADDR      (RES_A)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .opcode     (opcode),
        .result     (result),
        .done       (done),
        .error      (error),
        .host_busy  (host_busy),
        .addr       (addr),
        .databus_out(databus_out),
        .databus_in (databus_in),
        .cs         (cs),
        .wr         (wr),
        .rd         (rd),
        .end_ack    (end_ack),
        .cmd_end    (cmd_end),
        .fpu_busy   (fpu_busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Stand-in for the FPU arithmetic: the divide case is the known answer, others a fixed mix.
    function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] op);
        if (op == OP_DIV && a == 32'h458ebf1f && b == 32'h449a522c) return 32'h406ccca7;
        return (a ^ {b[15:0], b[31:16]}) + {4{op}};
    endfunction

    // ---------------- FPU model ----------------
    int          cmd_delay = 0;
    int          ack_hold  = 1;
    logic        no_end    = 1'b0;
    logic [7:0]  regs [64];
    logic [31:0] mres = '0;
    logic        pending;
    int          cnt, ack_cnt;
    typedef struct packed {logic [5:0] a; logic [7:0] d;} wlog_t;
    wlog_t       wlog[$];
    logic [5:0]  roff;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cmd_end <= 1'b0;
            pending <= 1'b0;
            cnt     <= 0;
            ack_cnt <= 0;
        end else begin
            if (!cs && !wr) begin
                regs[addr] <= databus_out;
                wlog.push_back({addr, databus_out});
                if (addr == CMD_A) begin
                    mres    <= fpu_ref({regs[3], regs[2], regs[1], regs[0]},
                                       {regs[7], regs[6], regs[5], regs[4]}, databus_out);
                    pending <= 1'b1;
                    cnt     <= cmd_delay;
                    ack_cnt <= 0;
                end
            end
            if (pending) begin
                if (no_end) pending <= 1'b0;
                else if (cnt == 0) begin
                    cmd_end <= 1'b1;
                    pending <= 1'b0;
                end else cnt <= cnt - 1;
            end
            if (cmd_end && end_ack) begin
                if (ack_cnt + 1 >= ack_hold) cmd_end <= 1'b0;
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    assign roff = addr - RES_A;
    always_comb begin
        databus_in = 8'h00;
        if (!cs && !rd) databus_in = mres[{roff[1:0], 3'b000} +: 8];
    end

    // ---------------- bus monitor (samples on the falling edge) ----------------
    int         cyc = 0, rd_cnt = 0, ack_rise = 0, ack_len = 0, done_cnt = 0;
    int         t_fall = 0, t_done = 0, viol = 0;
    logic       cs_p = 1'b1, ack_p = 1'b0, ce_p = 1'b0;
    logic [5:0] a_p = '0;
    logic [7:0] d_p = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (arst_n) begin
            if ((!wr && !rd) || (cs != (wr && rd)) || (!cs && !cs_p) ||
                (cs && (addr != a_p || databus_out != d_p)))
                viol <= viol + 1;
            if (!rd) rd_cnt <= rd_cnt + 1;
        end
        if (end_ack && !ack_p) begin
            ack_rise <= ack_rise + 1;
            ack_len  <= 1;
        end else if (end_ack) ack_len <= ack_len + 1;
        if (ce_p && !cmd_end) t_fall <= cyc;
        if (done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
        end
        cs_p  <= cs;
        ack_p <= end_ack;
        ce_p  <= cmd_end;
        a_p   <= addr;
        d_p   <= databus_out;
    end

    // ---------------- scoreboard and transaction tasks ----------------
    typedef struct packed {logic [31:0] res; logic err;} exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op;
        int          dly;
        logic        noend;
        logic [31:0] er;
        logic        ee;
    } vec_t;
    vec_t vecs[5];

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                               input logic [31:0] er, input logic ee);
        op_a   = a;
        op_b   = b;
        opcode = op;
        start  = 1'b1;
        sb.push_back({er, ee});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_txn(input string tag);
        exp_t e;
        bit   seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, " done_seen"}, 64'(seen), 64'(1));
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " result"}, 64'(result), 64'(e.res));
            check({tag, " error"}, 64'(error), 64'(e.err));
            check({tag, " busy_with_done"}, 64'(host_busy), 64'(1));
            @(negedge clk);
            check({tag, " idle_after_done"}, 64'({host_busy, done}), 64'(0));
        end
    endtask

    task automatic run_txn(input vec_t v, input int hold, input string tag, output int lat);
        cmd_delay = v.dly;
        ack_hold  = hold;
        no_end    = v.noend;
        lat       = -1;
        drive_start(v.a, v.b, v.op, v.er, v.ee);
        for (int k = 1; k < 400; k++) begin
            if (!cs && lat < 0) lat = k;
            if (done) break;
            @(negedge clk);
        end
        finish_txn(tag);
    endtask

    logic [7:0] div_bytes [9];

    initial begin
        int   lat, base, r0, a0, d0, csb;
        bit   seen;
        vec_t v;

        div_bytes = '{8'h1f, 8'hbf, 8'h8e, 8'h45, 8'h2c, 8'h52, 8'h9a, 8'h44, OP_DIV};
        vecs[0] = '{32'h458ebf1f, 32'h449a522c, OP_DIV, 5, 1'b0, 32'h406ccca7, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000000, 8'h01, 0, 1'b0,
                    fpu_ref(32'h0, 32'h0, 8'h01), 1'b0};
        vecs[2] = '{32'hffffffff, 32'h12345678, 8'h02, 3, 1'b0,
                    fpu_ref(32'hffffffff, 32'h12345678, 8'h02), 1'b0};
        vecs[3] = '{32'hcafef00d, 32'h0badc0de, 8'h04, 0, 1'b1, 32'h0, 1'b1};
        vecs[4] = '{32'ha5a55a5a, 32'h5a5aa5a5, 8'h07, 9, 1'b0,
                    fpu_ref(32'ha5a55a5a, 32'h5a5aa5a5, 8'h07), 1'b0};

        // Asynchronous reset takes effect before any clock edge.
        #1 arst_n = 1'b0;
        #1;
        check("reset ctl", 64'({cs, wr, rd, end_ack, done, error, host_busy}), 64'(7'b1110000));
        check("reset result", 64'(result), 64'(0));
        check("reset bus", 64'({addr, databus_out}), 64'(0));
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            base = wlog.size();
            r0   = rd_cnt;
            a0   = ack_rise;
            run_txn(vecs[i], 1, $sformatf("vec%0d", i), lat);
            if (i == 0) begin
                check("start_to_cs latency", 64'(lat), 64'(2));
                check("div write count", 64'(wlog.size() - base), 64'(9));
                for (int j = 0; j < 9; j++)
                    check($sformatf("div write %0d", j), 64'(wlog[base + j]),
                          64'({6'(j), div_bytes[j]}));
            end
            if (vecs[i].noend) begin
                repeat (2) @(negedge clk);
                check("timeout read strobes", 64'(rd_cnt - r0), 64'(0));
                check("timeout ack pulses", 64'(ack_rise - a0), 64'(1));
                check("timeout ack width", 64'(ack_len), 64'(1));
                check("timeout error held", 64'(error), 64'(1));
            end
        end

        // Busy gate: no access while the FPU is busy, repeated start ignored.
        d0        = done_cnt;
        csb       = 0;
        fpu_busy  = 1'b1;
        cmd_delay = 2;
        ack_hold  = 1;
        no_end    = 1'b0;
        drive_start(32'h11223344, 32'h55667788, 8'h05,
                    fpu_ref(32'h11223344, 32'h55667788, 8'h05), 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (!cs) csb++;
            start = (k == 4);
            if (k == 4) op_a = 32'hdeadbeef;
            @(negedge clk);
        end
        start    = 1'b0;
        fpu_busy = 1'b0;
        check("busy cs_low count", 64'(csb), 64'(0));
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_txn("busy");
        repeat (60) @(negedge clk);
        check("busy done count", 64'(done_cnt - d0), 64'(1));

        // Reset in the middle of the result reads.
        cmd_delay = 2;
        drive_start(32'h01020304, 32'h05060708, 8'h06, 32'h0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (!rd) seen = 1'b1;
            else @(negedge clk);
        end
        check("midop reached reads", 64'(seen), 64'(1));
        #2 arst_n = 1'b0;
        #1;
        check("midop reset ctl", 64'({cs, wr, rd, end_ack, done, error, host_busy}),
              64'(7'b1110000));
        check("midop reset result", 64'(result), 64'(0));
        check("midop reset bus", 64'({addr, databus_out}), 64'(0));
        sb.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        #2 arst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midop no done", 64'(done_cnt - d0), 64'(0));
        v = '{32'h3f800000, 32'h40000000, 8'h01, 1, 1'b0,
              fpu_ref(32'h3f800000, 32'h40000000, 8'h01), 1'b0};
        run_txn(v, 1, "after_reset", lat);

        // Handshake: cmd_end stays high three cycles after end_ack rises.
        v = '{32'h87654321, 32'h0f0f0f0f, OP_DIV, 1, 1'b0,
              fpu_ref(32'h87654321, 32'h0f0f0f0f, OP_DIV), 1'b0};
        run_txn(v, 3, "handshake", lat);
        repeat (2) @(negedge clk);
        check("handshake ack width", 64'(ack_len), 64'(4));
        check("handshake done after cmd_end low", 64'(t_done - t_fall), 64'(1));

        check("bus protocol violations", 64'(viol), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
